// File: rtl/picosoc_bus_arbiter.sv
// picosoc_bus_arbiter: two-master / one-slave arbiter for the PicoSoC native
// valid/ready memory bus. Round-robin between the CPU (m0) and DMA (m1), with
// the grant held until the transaction completes, plus a bus timeout watchdog
// that force-completes with ERR_RDATA and records the failing master/address.
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   m0_* / m1_*                      master request (valid/wstrb/addr/wdata)
//                                    and completion (ready/rdata)
//   s_*                              downstream slave request / completion
//   err_flag, err_master, err_addr   sticky timeout record
//   err_clr                          single-cycle clear of err_flag
module picosoc_bus_arbiter #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   input  logic        s_ready,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,

   output logic        err_flag,
   input  logic        err_clr,
   output logic        err_master,
   output logic [31:0] err_addr
);

   // Counter is at least one bit wide so a disabled watchdog still elaborates.
   localparam int unsigned  CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_flag_q, err_flag_d;
   logic            err_master_q, err_master_d;
   logic [31:0]     err_addr_q, err_addr_d;

   logic            busy;
   logic            gnt_valid;
   logic [3:0]      gnt_wstrb;
   logic [31:0]     gnt_addr;
   logic [31:0]     gnt_wdata;
   logic            done;
   logic            timeout_hit;

   // Granted master's request, selected by the registered grant.
   always_comb begin
      busy      = (state_q == BUSY);
      gnt_valid = grant_q ? m1_valid : m0_valid;
      gnt_wstrb = grant_q ? m1_wstrb : m0_wstrb;
      gnt_addr  = grant_q ? m1_addr  : m0_addr;
      gnt_wdata = grant_q ? m1_wdata : m0_wdata;
      done      = busy && gnt_valid && s_ready;
      // s_ready in the same cycle takes priority over the watchdog.
      timeout_hit = (TIMEOUT != 0) && busy && gnt_valid && !s_ready
                    && (cnt_q == TO_VAL);
   end

   // Slave request and master completion paths (combinational by design).
   always_comb begin
      s_valid = 1'b0;
      s_wstrb = 4'h0;
      s_addr  = 32'h0;
      s_wdata = 32'h0;
      if (busy) begin
         s_valid = gnt_valid && !timeout_hit;
         s_wstrb = gnt_wstrb;
         s_addr  = gnt_addr;
         s_wdata = gnt_wdata;
      end
      m0_ready = (done || timeout_hit) && !grant_q;
      m1_ready = (done || timeout_hit) &&  grant_q;
      m0_rdata = timeout_hit ? ERR_RDATA : s_rdata;
      m1_rdata = timeout_hit ? ERR_RDATA : s_rdata;
   end

   // Next-state: arbitration, completion, watchdog and error record.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      err_flag_d   = err_flag_q;
      err_master_d = err_master_q;
      err_addr_d   = err_addr_q;

      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               // On a tie the master that did not complete last wins.
               grant_d = (m0_valid && m1_valid) ? !last_q : m1_valid;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!gnt_valid) begin
               // Master abandoned the request: drop it without touching last.
               state_d = IDLE;
            end else if (done || timeout_hit) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A timeout capture overrides a coincident clear.
      if (timeout_hit) begin
         err_flag_d   = 1'b1;
         err_master_d = grant_q;
         err_addr_d   = gnt_addr;
      end else if (err_clr) begin
         err_flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         err_flag_q   <= 1'b0;
         err_master_q <= 1'b0;
         err_addr_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         err_flag_q   <= err_flag_d;
         err_master_q <= err_master_d;
         err_addr_q   <= err_addr_d;
      end
   end

   assign err_flag   = err_flag_q;
   assign err_master = err_master_q;
   assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Self-checking bench for picosoc_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction-level
// reference model (owner / elapsed-cycles / last-winner bookkeeping).
module tb_picosoc_bus_arbiter;

   localparam int unsigned TO   = 4;
   localparam logic [31:0] ERRD = 32'hBADB_AD00;

   logic        clk, resetn;
   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        err_flag, err_clr, err_master;
   logic [31:0] err_addr;

   picosoc_bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERRD)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .err_flag(err_flag), .err_clr(err_clr), .err_master(err_master),
      .err_addr(err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state: owner (-1 = nobody), BUSY cycles already spent,
   // last master to complete, error record, and a log of grants/completions.
   int          own  = -1;
   int          age  = 0;
   int          last = 1;
   bit          merr = 1'b0;
   bit          merrm = 1'b0;
   logic [31:0] merra = 32'h0;
   int          glog[$];
   int          ncomp = 0;

   // Expected outputs for the current cycle.
   logic        e_sv, e_r0, e_r1, e_to, e_gv;
   logic [31:0] e_rd, e_addr, e_wd;
   logic [3:0]  e_ws;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_comb();
      e_sv = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_to = 1'b0; e_gv = 1'b0;
      e_rd = s_rdata; e_addr = 32'h0; e_wd = 32'h0; e_ws = 4'h0;
      if (own >= 0) begin
         e_gv   = (own == 1) ? m1_valid : m0_valid;
         e_addr = (own == 1) ? m1_addr  : m0_addr;
         e_wd   = (own == 1) ? m1_wdata : m0_wdata;
         e_ws   = (own == 1) ? m1_wstrb : m0_wstrb;
         e_to   = e_gv && !s_ready && (age == int'(TO));
         e_sv   = e_gv && !e_to;
         if (e_gv && (s_ready || e_to)) begin
            if (own == 1) e_r1 = 1'b1; else e_r0 = 1'b1;
         end
         if (e_to) e_rd = ERRD;
      end
   endtask

   task automatic model_seq();
      if (e_to) begin
         merr = 1'b1; merrm = (own == 1); merra = e_addr;
      end else if (err_clr) begin
         merr = 1'b0;
      end
      if (own < 0) begin
         if (m0_valid || m1_valid) begin
            own = (m0_valid && m1_valid) ? 1 - last : (m1_valid ? 1 : 0);
            age = 0;
            glog.push_back(own);
         end
      end else if (!e_gv) begin
         own = -1;
      end else if (e_r0 || e_r1) begin
         last = own; own = -1; ncomp++;
      end else begin
         age++;
      end
   endtask

   // One clock: check every output at the falling edge, advance the model
   // just after the rising edge; callers change inputs after it returns.
   task automatic cycle();
      @(negedge clk);
      model_comb();
      chk("s_valid",  32'(s_valid),  32'(e_sv));
      chk("m0_ready", 32'(m0_ready), 32'(e_r0));
      chk("m1_ready", 32'(m1_ready), 32'(e_r1));
      if (e_r0) chk("m0_rdata", m0_rdata, e_rd);
      if (e_r1) chk("m1_rdata", m1_rdata, e_rd);
      chk("s_addr",   s_addr,  e_addr);
      chk("s_wdata",  s_wdata, e_wd);
      chk("s_wstrb",  32'(s_wstrb), 32'(e_ws));
      chk("err_flag",   32'(err_flag),   32'(merr));
      chk("err_master", 32'(err_master), 32'(merrm));
      chk("err_addr",   err_addr, merra);
      @(posedge clk);
      #1;
      model_seq();
   endtask

   task automatic set_m(input int m, input bit v, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] d);
      if (m == 0) begin
         m0_valid = v; m0_wstrb = ws; m0_addr = a; m0_wdata = d;
      end else begin
         m1_valid = v; m1_wstrb = ws; m1_addr = a; m1_wdata = d;
      end
   endtask

   task automatic model_reset();
      own = -1; age = 0; last = 1; merr = 1'b0; merrm = 1'b0; merra = 32'h0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      int base;
      logic [31:0] r;

      resetn = 1'b0; err_clr = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Reset state
      chk("rst_s_valid",  32'(s_valid),  32'h0);
      chk("rst_err_flag", 32'(err_flag), 32'h0);
      chk("rst_err_addr", err_addr,      32'h0);
      chk("rst_m0_ready", 32'(m0_ready), 32'h0);

      // 1: m0 read, slave ready on the 4th BUSY cycle
      set_m(0, 1'b1, 4'h0, 32'h0000_1000, 32'h0);
      s_rdata = 32'h1234_5678;
      cycle();
      repeat (3) cycle();
      s_ready = 1'b1;
      cycle();
      chk("t1_completions", 32'(ncomp), 32'd1);
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      s_ready = 1'b0;
      cycle();

      // 2: continuous contention, grants alternate starting with m1 (m0 went last)
      glog.delete();
      base = ncomp;
      set_m(0, 1'b1, 4'hF, 32'h0000_0100, 32'hA0A0_A0A0);
      set_m(1, 1'b1, 4'h3, 32'h0000_0200, 32'hB0B0_B0B0);
      s_ready = 1'b1;
      n = 0;
      while (ncomp < base + 4 && n < 20) begin
         cycle();
         n++;
      end
      chk("t2_done_in_budget", 32'(ncomp - base), 32'd4);
      if (glog.size() >= 4) begin
         chk("t2_grant0", 32'(glog[0]), 32'd1);
         chk("t2_grant1", 32'(glog[1]), 32'd0);
         chk("t2_grant2", 32'(glog[2]), 32'd1);
         chk("t2_grant3", 32'(glog[3]), 32'd0);
      end else begin
         chk("t2_grant_count", 32'(glog.size()), 32'd4);
      end
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
      s_ready = 1'b0;
      cycle();

      // 4a: s_ready in exactly the timeout cycle -> normal completion
      set_m(0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      s_rdata = 32'h5555_AAAA;
      cycle();
      repeat (TO) cycle();
      s_ready = 1'b1;
      cycle();
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      s_ready = 1'b0;
      cycle();
      chk("t4a_err_flag", 32'(err_flag), 32'h0);

      // 3: m1 write to a dead slave times out in the (TO+1)th BUSY cycle
      set_m(1, 1'b1, 4'hF, 32'h0300_0010, 32'hCAFE_F00D);
      cycle();
      n = 0;
      begin
         bit seen = 1'b0;
         while (!seen && n < 12) begin
            cycle();
            n++;
            seen = e_r1;
         end
      end
      chk("t3_busy_cycles", 32'(n), 32'(TO + 1));
      set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle();
      chk("t3_err_flag",   32'(err_flag),   32'h1);
      chk("t3_err_master", 32'(err_master), 32'h1);
      chk("t3_err_addr",   err_addr,        32'h0300_0010);

      // 4b: err_clr coincident with a new timeout -> flag stays set, record updates
      set_m(0, 1'b1, 4'h0, 32'h0000_0044, 32'h0);
      cycle();
      repeat (TO) cycle();
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle();
      chk("t4b_err_flag",   32'(err_flag),   32'h1);
      chk("t4b_err_master", 32'(err_master), 32'h0);
      chk("t4b_err_addr",   err_addr,        32'h0000_0044);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      cycle();

      // 5: reset during BUSY aborts at once; afterwards m0 wins the tie
      set_m(0, 1'b1, 4'h1, 32'h0000_0080, 32'h1111_2222);
      cycle();
      cycle();
      s_ready = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("t5_s_valid",  32'(s_valid),  32'h0);
      chk("t5_m0_ready", 32'(m0_ready), 32'h0);
      chk("t5_m1_ready", 32'(m1_ready), 32'h0);
      chk("t5_s_addr",   s_addr,        32'h0);
      chk("t5_s_wstrb",  32'(s_wstrb),  32'h0);
      model_reset();
      s_ready = 1'b0;
      set_m(1, 1'b1, 4'h2, 32'h0000_0090, 32'h3333_4444);
      @(posedge clk);
      #1 resetn = 1'b1;
      glog.delete();
      cycle();
      cycle();
      chk("t5_first_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);
      s_ready = 1'b1;
      cycle();
      s_ready = 1'b0;
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) cycle();

      // 6: m1 abandons its request; pending m0 is granted after one IDLE cycle
      set_m(1, 1'b1, 4'h0, 32'h0000_0500, 32'h0);
      cycle();
      cycle();
      set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
      set_m(0, 1'b1, 4'h0, 32'h0000_0600, 32'h0);
      glog.delete();
      cycle();
      chk("t6_no_m1_ready", 32'(e_r1 | m1_ready), 32'h0);
      cycle();
      cycle();
      chk("t6_m0_granted", 32'(s_valid), 32'h1);
      chk("t6_m0_addr",    s_addr,       32'h0000_0600);
      s_ready = 1'b1;
      cycle();
      s_ready = 1'b0;
      set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle();

      // Randomized traffic: masters hold requests until served, rarely abandon
      for (int i = 0; i < 3000; i++) begin
         if (!m0_valid || e_r0) begin
            r = $urandom;
            set_m(0, r[0], 4'($urandom), $urandom, $urandom);
         end else if ($urandom_range(63) == 0) begin
            m0_valid = 1'b0;
         end
         if (!m1_valid || e_r1) begin
            r = $urandom;
            set_m(1, r[0], 4'($urandom), $urandom, $urandom);
         end else if ($urandom_range(63) == 0) begin
            m1_valid = 1'b0;
         end
         s_ready = ($urandom_range(2) == 0);
         s_rdata = $urandom;
         err_clr = ($urandom_range(15) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/picosoc_bus_arbiter.md
# picosoc_bus_arbiter

Two-master, one-slave arbiter for the PicoSoC native valid/ready memory bus. It lets the CPU (master 0) and a DMA/frame-grabber engine (master 1) share one downstream `iomem`-style slave port. Arbitration is round-robin, and each grant is held until the transaction completes. A bus timeout watchdog returns an error word and records the failing address, so a dead slave cannot stall the CPU forever.

## Interface

Parameters:
- `TIMEOUT`, 255: number of BUSY cycles without `s_ready` before a forced completion. 0 disables the watchdog.
- `ERR_RDATA`, 32'hFFFF_FFFF: read data returned on a timed-out transaction.

Ports:
- `clk` in 1: single clock domain.
- `resetn` in 1: reset, asynchronous and active-low.
- `m0_valid` in 1: master 0 (CPU) request.
- `m0_ready` out 1: master 0 completion strobe.
- `m0_wstrb` in 4: master 0 byte write strobes; 0 means read.
- `m0_addr` in 32: master 0 byte address.
- `m0_wdata` in 32: master 0 write data.
- `m0_rdata` out 32: master 0 read data.
- `m1_valid`, `m1_ready`, `m1_wstrb`, `m1_addr`, `m1_wdata`, `m1_rdata`: same as the m0 ports, for master 1 (DMA).
- `s_valid` out 1: slave request.
- `s_ready` in 1: slave completion.
- `s_wstrb` out 4, `s_addr` out 32, `s_wdata` out 32: slave request fields.
- `s_rdata` in 32: slave read data.
- `err_flag` out 1: sticky timeout flag.
- `err_clr` in 1: single-cycle clear for `err_flag`.
- `err_master` out 1: master that timed out.
- `err_addr` out 32: address of the timed-out transaction.

## Operation

**State machine: IDLE, BUSY.**

IDLE:
- If neither valid is high: stay in IDLE.
- If exactly one valid is high: grant that master.
- If both are high: grant the master other than `last`.
- On a grant: `grant` is registered, the timeout counter clears, and the state goes to BUSY.

BUSY:
- `s_valid` = granted master's valid.
- `s_addr`, `s_wdata`, `s_wstrb` = granted master's fields, muxed combinationally from the registered `grant`.
- On `s_ready`=1:
  - The granted master's ready = 1 in the same cycle, with `mX_rdata` = `s_rdata`.
  - Next state is IDLE and `last` <= `grant`.
- On timeout (counter == `TIMEOUT`, `TIMEOUT`≠0, `s_ready`=0):
  - `s_valid`=0 in that cycle.
  - The granted master's ready = 1 with rdata = `ERR_RDATA`.
  - `err_flag` <= 1, `err_master` <= `grant`, `err_addr` <= granted address.
  - Next state is IDLE and `last` <= `grant`.
- Otherwise: the counter increments and the state stays in BUSY.
- If the granted master's valid drops before completion (protocol violation): no ready is issued, the state goes to IDLE next cycle, and `last` is unchanged.

Other rules:
- The non-granted master's ready is always 0.
- Both `mX_rdata` outputs carry `s_rdata`, or `ERR_RDATA` in the timeout cycle; they are only meaningful while that master's ready is high.
- In IDLE, `s_valid`, `s_wstrb`, `s_addr` and `s_wdata` are all 0.
- Counter width is $clog2(`TIMEOUT`+1). It saturates and never wraps.
- `s_ready` and timeout in the same cycle: `s_ready` wins, normal completion, no error.
- `err_clr` and a timeout in the same cycle: the set wins and the capture happens.
- A second timeout while `err_flag`=1 overwrites `err_master`/`err_addr`.

**Reset (asynchronous, resetn=0):**
- State = IDLE; `grant`=0; `last`=1, so master 0 wins the first tie; counter=0.
- `err_flag`=0, `err_master`=0, `err_addr`=0.
- All ready outputs 0; `s_valid`=0 and all `s_*` request fields 0.
- Reset asserted mid-transaction aborts it immediately. No ready is issued, and masters must re-issue after reset.

## Timing

- Arbitration latency: 1 cycle. A valid sampled in IDLE at edge N gives `s_valid`=1 in cycle N+1.
- Completion is combinational from `s_ready` to `mX_ready`. The slave sees the same zero-wait-state protocol as the CPU would without the arbiter, plus the one grant cycle.
- Minimum transaction time is 2 cycles (grant, then ready). At least one IDLE cycle separates consecutive grants.
- Timeout completion occurs in the (`TIMEOUT`+1)th BUSY cycle. `err_flag`, `err_master` and `err_addr` are visible the following cycle.
- Under continuous contention, grants strictly alternate m0, m1, m0, …; neither master waits more than one transaction.

## Test plan

1. m0 read only, slave ready 3 cycles after `s_valid`, `s_rdata`=32'h1234_5678 → `s_valid` 1 cycle after `m0_valid`; `m0_ready` pulses once with `m0_rdata`=32'h1234_5678; `m1_ready` stays 0.
2. m0 and m1 both valid from the cycle after reset, slave always ready next cycle → grant order m0, m1, m0, m1; each `s_addr`/`s_wdata`/`s_wstrb` matches the granted master.
3. `TIMEOUT`=4, m1 write to 32'h0300_0010, slave never ready → `m1_ready`=1 in the 5th BUSY cycle with `s_valid`=0; `err_flag`=1, `err_master`=1, `err_addr`=32'h0300_0010.
4. `s_ready` asserted in exactly the timeout cycle → normal completion with `s_rdata`; `err_flag` stays 0. Separately, pulse `err_clr` in the cycle of a new timeout → `err_flag` remains 1.
5. Assert `resetn`=0 during BUSY with m0 granted → all outputs 0 immediately; after release, simultaneous requests grant m0 first.
6. m1 drops valid in BUSY before `s_ready` → no `m1_ready`; IDLE next cycle; a pending m0 request is granted the cycle after.
